// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU operation codes, EX-stage FSM states and
// the EX/MEM control bundle. Imported by the decode and execute stages.
// No ports; compile before any file that imports it.
package pipeline_pkg;

  localparam int REG_AW = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } ex_state_e;

  // Everything that travels from ID/EX to EX/MEM besides the ALU result.
  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       ir;
    logic [31:0]       store_data;
    logic [REG_AW-1:0] write_addr;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              pc_to_reg;
    logic              reg_write;
  } exmem_ctl_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX input bundle, EX/MEM output bundle, flush and (with FORWARD_EN) the
// writeback forwarding source. slave = the execute stage, master = its
// surroundings (decode, memory stage, writeback).
interface ex_stage_if;
  import pipeline_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       iPC, iIR, iread_data1, iread_data2, isign_ext;
  logic [REG_AW-1:0] iwrite_addr;
  logic [3:0]        ialuop;
  logic              ialusrc, imem_read, imem_write, imem_to_reg, ipc_to_reg, ireg_write;
  logic              out_stall;
  logic              out_valid;
  logic [31:0]       oPC, oIR, oalu_result, ostore_data;
  logic [REG_AW-1:0] owrite_addr;
  logic              omem_read, omem_write, omem_to_reg, opc_to_reg, oreg_write;
`ifdef FORWARD_EN
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_write_addr;
  logic [31:0]       wb_data;
`endif

  modport slave (
`ifdef FORWARD_EN
    input  wb_reg_write, wb_write_addr, wb_data,
`endif
    input  flush, in_valid, iPC, iIR, iread_data1, iread_data2, isign_ext,
    input  iwrite_addr, ialuop, ialusrc, imem_read, imem_write, imem_to_reg,
    input  ipc_to_reg, ireg_write, out_stall,
    output in_ready, out_valid, oPC, oIR, oalu_result, ostore_data, owrite_addr,
    output omem_read, omem_write, omem_to_reg, opc_to_reg, oreg_write
  );

  modport master (
`ifdef FORWARD_EN
    output wb_reg_write, wb_write_addr, wb_data,
`endif
    output flush, in_valid, iPC, iIR, iread_data1, iread_data2, isign_ext,
    output iwrite_addr, ialuop, ialusrc, imem_read, imem_write, imem_to_reg,
    output ipc_to_reg, ireg_write, out_stall,
    input  in_ready, out_valid, oPC, oIR, oalu_result, ostore_data, owrite_addr,
    input  omem_read, omem_write, omem_to_reg, opc_to_reg, oreg_write
  );

endinterface

// File: rtl/ex_stage_mul_seq.sv
// ex_mul_seq: iterative shift-add multiplier, one multiplier bit per cycle, low 32 bits.
// Latency: start at edge N, done is high during the cycle before edge N+MUL_CYCLES.
// Backpressure: hold freezes the final step (done low) until released; kill aborts.
// Ports: clock, reset (async active-low), start/op_a/op_b, kill, hold, done, product.
module ex_mul_seq #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        kill,
  input  logic        hold,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        done,
  output logic [31:0] product
);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [31:0]   mcand, mplier, acc;
  logic          last, step;

  assign last    = busy && (cnt == LAST);
  assign step    = busy && !(last && hold);
  // The partial sum including the current bit; on the last step this is the
  // finished product, so the consumer can capture it at the same edge.
  assign product = acc + (mplier[0] ? mcand : 32'd0);
  assign done    = last && !hold && !kill;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (kill) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
    end else if (step) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= last ? '0 : cnt + CW'(1);
      busy   <= !last;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS32 execute stage; inline ALU + forwarding, iterative MUL via ex_mul_seq.
// Latency: 1 edge for ALU ops, MUL_CYCLES edges for MUL; flush drops output and MUL.
// Backpressure: out_stall with out_valid holds EX/MEM and deasserts in_ready.
// Ports: clock, reset (async active-low), bus (ex_stage_if.slave). Optional
// macro FORWARD_EN adds the wb_* inputs and EX/MEM + WB operand forwarding.
module ex_stage
  import pipeline_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  ex_stage_if.slave   bus
);
  ex_state_e   state;
  logic        out_valid_q;
  exmem_ctl_t  out_q, pend_q, in_ctl;
  logic [31:0] alu_q;

  logic        stalled, in_ready, accept, is_mul;
  logic [31:0] rd1_f, rd2_f, op_b, alu_res, mul_product;
  logic        mul_done;

  assign stalled  = out_valid_q && bus.out_stall;
  assign in_ready = (state == IDLE) && !stalled && reset;
  assign accept   = bus.in_valid && in_ready && !bus.flush;
  assign is_mul   = (bus.ialuop == ALU_MUL);

`ifdef FORWARD_EN
  logic [REG_AW-1:0] rs, rt;
  logic              ex_fwd_ok, wb_fwd_ok;
  assign rs = bus.iIR[25:21];
  assign rt = bus.iIR[20:16];
  // Loads are excluded from EX/MEM forwarding: their data does not exist yet.
  assign ex_fwd_ok = out_valid_q && out_q.reg_write && !out_q.mem_read && (out_q.write_addr != '0);
  assign wb_fwd_ok = bus.wb_reg_write && (bus.wb_write_addr != '0);

  always_comb begin
    rd1_f = bus.iread_data1;
    if (ex_fwd_ok && out_q.write_addr == rs)      rd1_f = alu_q;
    else if (wb_fwd_ok && bus.wb_write_addr == rs) rd1_f = bus.wb_data;
    rd2_f = bus.iread_data2;
    if (ex_fwd_ok && out_q.write_addr == rt)      rd2_f = alu_q;
    else if (wb_fwd_ok && bus.wb_write_addr == rt) rd2_f = bus.wb_data;
  end
`else
  assign rd1_f = bus.iread_data1;
  assign rd2_f = bus.iread_data2;
`endif

  assign op_b = bus.ialusrc ? bus.isign_ext : rd2_f;

  always_comb begin
    alu_res = 32'd0;
    case (bus.ialuop)
      ALU_AND: alu_res = rd1_f & op_b;
      ALU_OR:  alu_res = rd1_f | op_b;
      ALU_ADD: alu_res = rd1_f + op_b;
      ALU_SUB: alu_res = rd1_f - op_b;
      ALU_SLT: alu_res = {31'd0, $signed(rd1_f) < $signed(op_b)};
      ALU_NOR: alu_res = ~(rd1_f | op_b);
      ALU_SLL: alu_res = op_b << bus.iIR[10:6];
      ALU_SRL: alu_res = op_b >> bus.iIR[10:6];
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    in_ctl            = '0;
    in_ctl.pc         = bus.iPC;
    in_ctl.ir         = bus.iIR;
    in_ctl.store_data = rd2_f;
    in_ctl.write_addr = bus.iwrite_addr;
    in_ctl.mem_read   = bus.imem_read;
    in_ctl.mem_write  = bus.imem_write;
    in_ctl.mem_to_reg = bus.imem_to_reg;
    in_ctl.pc_to_reg  = bus.ipc_to_reg;
    in_ctl.reg_write  = bus.ireg_write;
  end

  ex_mul_seq #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (accept && is_mul),
    .kill    (bus.flush),
    .hold    (stalled),
    .op_a    (rd1_f),
    .op_b    (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      pend_q      <= '0;
      alu_q       <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      state       <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              // Controls wait in pend_q; the old output drains this edge.
              pend_q      <= in_ctl;
              state       <= MUL;
              out_valid_q <= 1'b0;
            end else begin
              out_q       <= in_ctl;
              alu_q       <= alu_res;
              out_valid_q <= 1'b1;
            end
          end else if (!stalled) begin
            out_valid_q <= 1'b0;
          end
        end
        MUL: begin
          if (mul_done) begin
            out_q       <= pend_q;
            alu_q       <= mul_product;
            out_valid_q <= 1'b1;
            state       <= IDLE;
          end else if (!stalled) begin
            out_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.oPC         = out_q.pc;
  assign bus.oIR         = out_q.ir;
  assign bus.oalu_result = alu_q;
  assign bus.ostore_data = out_q.store_data;
  assign bus.owrite_addr = out_q.write_addr;
  assign bus.omem_read   = out_q.mem_read;
  assign bus.omem_write  = out_q.mem_write;
  assign bus.omem_to_reg = out_q.mem_to_reg;
  assign bus.opc_to_reg  = out_q.pc_to_reg;
  assign bus.oreg_write  = out_q.reg_write;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the pipelined MIPS32 core. Consumes the ID/EX bundle, resolves operands, and computes single-cycle ALU results or a multi-cycle 32×32 multiply. Registers everything into the EX/MEM bundle using a valid/ready handshake toward decode and a stall input from the memory stage.

## Interface
Parameters:
- MUL_CYCLES, 32, multiply iterations, one bit per cycle; legal range 1–32.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- flush  in  1  drop the registered output and any in-flight multiply.
- in_valid  in  1  ID/EX bundle valid.
- in_ready  out  1  stage accepts the bundle this cycle.
- iPC, iIR, iread_data1, iread_data2, isign_ext  in  32 each  ID/EX data.
- iwrite_addr  in  5  destination register.
- ialuop  in  4  operation code.
- ialusrc, imem_read, imem_write, imem_to_reg, ipc_to_reg, ireg_write  in  1 each  controls.
- out_stall  in  1  MEM stage cannot take the EX/MEM bundle.
- out_valid  out  1  EX/MEM bundle valid.
- oPC, oIR, oalu_result, ostore_data  out  32 each  EX/MEM data.
- owrite_addr  out  5; omem_read, omem_write, omem_to_reg, opc_to_reg, oreg_write  out  1 each.
- wb_reg_write  in  1; wb_write_addr  in  5; wb_data  in  32  writeback forwarding source. Present only with FORWARD_EN.

## Operation
- Operand A is iread_data1 (forwarded). Operand B is isign_ext if ialusrc=1, else iread_data2 (forwarded). ostore_data is the forwarded iread_data2.
- ALU codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 0/1), 1100 NOR, 0011 SLL B by IR[10:6], 0100 SRL B by IR[10:6], 1000 MUL (low 32 bits, unsigned shift-add). Any other code gives result 0.
- ADD and SUB wrap modulo 2^32. There is no overflow trap.
- FSM states:
  - IDLE: accepts a bundle when in_valid && in_ready. For a non-MUL code, the EX/MEM registers load at the accept edge. For MUL, operands latch, cnt=0, and the FSM goes to MUL.
  - MUL: one shift-add per cycle. When cnt=MUL_CYCLES-1, the product and latched controls load into EX/MEM and the FSM returns to IDLE.
- in_ready = (state==IDLE) && !(out_valid && out_stall) && reset.
- While out_stall=1 and out_valid=1, EX/MEM holds. A completing MUL waits in MUL with the counter frozen.
- flush:
  - Next edge: out_valid←0 and state←IDLE.
  - A bundle offered in the flush cycle is not accepted (in_ready is ignored).
  - flush has priority over out_stall and over accept.
- When out_valid=0, data outputs keep their last values; only out_valid qualifies them.

## Timing
- Reset (asynchronous): out_valid=0, state=IDLE, cnt=0, and all o* outputs are 0. in_ready=0 while reset is low and 1 on the first cycle after release.
- Single-cycle ops: out_valid rises at the edge that accepts the bundle (latency 1).
- MUL: accepted at edge N, out_valid at edge N+MUL_CYCLES. in_ready=0 for cycles N+1 … N+MUL_CYCLES.
- Back-to-back: with out_stall=0, one single-cycle op is accepted per clock.
- Reset asserted mid-multiply: the partial product is discarded and no output appears.

## Configuration
- FORWARD_EN defined:
  - Compiles the wb_* ports and the forwarding muxes.
  - Priority 1 is the EX/MEM registers, when out_valid && oreg_write && !omem_read && owrite_addr==source reg && owrite_addr!=0.
  - Priority 2 is WB, when wb_reg_write && wb_write_addr==source reg && wb_write_addr!=0.
  - The source regs are IR[25:21] and IR[20:16].
  - Load-use stalls remain the job of the upstream hazard unit.
- FORWARD_EN undefined: the wb_* ports are absent and operands are used exactly as received.

## Structure
- Shared package pipeline_pkg holds the ALU code localparams, the FSM state enum (IDLE, MUL), and the 5-bit register-address width constant. The decode stage uses the same package.
- Sub-module ex_mul_seq is the iterative multiplier. It has start/operand inputs, a done pulse and product output, and a hold input driven by out_stall.
- The ALU and forwarding muxes stay inline in ex_stage.

## Test plan
- Reset check: hold reset low for 3 cycles with in_valid=1. Required: out_valid=0 and all o* outputs 0 throughout; in_ready=1 on the first cycle after release.
- ADD, A=0xFFFFFFFF, B=0x00000002, ialusrc=0. Required: oalu_result=0x00000001 and out_valid=1 one edge after accept. Follow with SLT 0xFFFFFFFF vs 0x1, which must give 0x00000001.
- MUL, 0x00012345 × 0x00000100. Required: oalu_result=0x01234500 exactly 32 edges after accept, with in_ready=0 in between. Assert out_stall for 5 cycles at completion; out_valid must stay 1 and the result must not change.
- FORWARD_EN: ADD writes r8=0x10, then SUB uses r8 with stale iread_data1=0 and B=0x3. Required: oalu_result=0x0D. Repeat with r8 sourced only from WB (wb_data=0x20), which must give 0x1D. Repeat with destination r0, which must not forward.
- Flush: assert flush 10 cycles into a MUL. Required: out_valid stays 0, in_ready=1 on the next cycle, and a following OR 0xF0|0x0F gives 0xFF.
